vector_wb_buffer: RTL and testbench

Writeback buffer between the vector execution units (lane array and mask unit) and the vector register file (veggie) write port. It accepts completed results from two producers, arbitrates them round-robin into a small in-order FIFO, and drains one entry per cycle into the VRF under a valid/ready handshake. It also answers a combinational pending-write query, so the issue logic can stall reads of registers whose writes are still in flight.

---
 rtl/vector_wb_buffer_pkg.sv | 24 ++
 rtl/vector_wb_buffer_if.sv | 54 +++++
 rtl/vector_wb_buffer_wb_fifo.sv | 71 +++++++
 rtl/vector_wb_buffer.sv | 83 ++++++++
 tb/tb_vector_wb_buffer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/vector_wb_buffer_pkg.sv
// Shared types and sizing for the vector writeback buffer.
package vector_wb_buffer_pkg;

  localparam int NUM_ELEMENTS = 32;
  localparam int ELEM_W       = 16;
  localparam int VREG_IDX_W   = 6;
  localparam int WB_DEPTH     = 4;
  localparam int VEC_W        = NUM_ELEMENTS * ELEM_W;
  localparam int WB_CNT_W     = $clog2(WB_DEPTH + 1);

  // One completed vector result waiting for the VRF write port.
  typedef struct packed {
    logic [VREG_IDX_W-1:0]   vd;
    logic [VEC_W-1:0]        data;
    logic [NUM_ELEMENTS-1:0] mask;
  } wb_entry_t;

  // Result producers feeding the buffer.
  typedef enum logic {
    WB_LANE = 1'b0,
    WB_MU   = 1'b1
  } wb_src_e;

endpackage

// File: rtl/vector_wb_buffer_if.sv
// Writeback bundle: producer handshakes, VRF write port and pending query.
interface vector_wb_buffer_if;
  import vector_wb_buffer_pkg::*;

  logic                    lane_valid;
  logic                    lane_ready;
  logic [VREG_IDX_W-1:0]   lane_vd;
  logic [VEC_W-1:0]        lane_data;
  logic [NUM_ELEMENTS-1:0] lane_mask;

  logic                    mu_valid;
  logic                    mu_ready;
  logic [VREG_IDX_W-1:0]   mu_vd;
  logic [VEC_W-1:0]        mu_data;
  logic [NUM_ELEMENTS-1:0] mu_mask;

  logic                    wr_valid;
  logic                    wr_ready;
  logic [VREG_IDX_W-1:0]   wr_vd;
  logic [VEC_W-1:0]        wr_data;
  logic [NUM_ELEMENTS-1:0] wr_mask;

  logic                    accomplished;
  logic [VREG_IDX_W-1:0]   query_vd;
  logic                    query_pending;
  logic [WB_CNT_W-1:0]     count;

  // Buffer side.
  modport slave (
    input  lane_valid, lane_vd, lane_data, lane_mask,
    output lane_ready,
    input  mu_valid, mu_vd, mu_data, mu_mask,
    output mu_ready,
    output wr_valid, wr_vd, wr_data, wr_mask,
    input  wr_ready,
    output accomplished,
    input  query_vd,
    output query_pending, count
  );

  // Producers, VRF and issue logic side.
  modport master (
    output lane_valid, lane_vd, lane_data, lane_mask,
    input  lane_ready,
    output mu_valid, mu_vd, mu_data, mu_mask,
    input  mu_ready,
    input  wr_valid, wr_vd, wr_data, wr_mask,
    output wr_ready,
    input  accomplished,
    output query_vd,
    input  query_pending, count
  );

endinterface

// File: rtl/vector_wb_buffer_wb_fifo.sv
// In-order FIFO of writeback entries; exposes per-slot valid and vd for lookup.
module wb_fifo
  import vector_wb_buffer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                              CLK,
  input  logic                              nRST,
  input  logic                              push,
  input  wb_entry_t                         push_entry,
  input  logic                              pop,
  output wb_entry_t                         head_entry,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic [DEPTH-1:0]                  entry_valid,
  output logic [DEPTH-1:0][VREG_IDX_W-1:0]  entry_vd
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  wb_entry_t        mem_q [DEPTH];

  // Pointer and occupancy update; pointers wrap naturally at a power-of-two depth.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PTR_W'(1);
    if (pop)  head_d = head_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards every queued entry.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; validity comes from the pointers alone.
  always_ff @(posedge CLK) begin
    if (push) mem_q[tail_q] <= push_entry;
  end

  // A slot is live when its distance from head is below the occupancy.
  always_comb begin
    entry_valid = '0;
    entry_vd    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = CNT_W'(PTR_W'(PTR_W'(i) - head_q)) < count_q;
      entry_vd[i]    = mem_q[i].vd;
    end
  end

  assign head_entry = mem_q[head_q];
  assign count      = count_q;

endmodule

// File: rtl/vector_wb_buffer.sv
// Writeback buffer: round-robin arbitration of lane and mask-unit results
// into an in-order FIFO that drains one entry per cycle to the VRF.
module vector_wb_buffer
  import vector_wb_buffer_pkg::*;
(
  input  logic               CLK,
  input  logic               nRST,
  vector_wb_buffer_if.slave  wb
);

  localparam int DEPTH = WB_DEPTH;

  wb_src_e                         grant;
  wb_src_e                         last_grant_q, last_grant_d;
  logic                            accomplished_q, accomplished_d;
  logic                            full, empty, push, pop, pending;
  wb_entry_t                       push_entry, head_entry;
  logic [WB_CNT_W-1:0]             count;
  logic [DEPTH-1:0]                entry_valid;
  logic [DEPTH-1:0][VREG_IDX_W-1:0] entry_vd;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK         (CLK),
    .nRST        (nRST),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .head_entry  (head_entry),
    .count       (count),
    .entry_valid (entry_valid),
    .entry_vd    (entry_vd)
  );

  assign full  = (count == WB_CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Grant: a lone requester wins; on contention the source not granted last wins.
  always_comb begin
    grant = (last_grant_q == WB_MU) ? WB_LANE : WB_MU;
    if (wb.lane_valid && !wb.mu_valid)      grant = WB_LANE;
    else if (!wb.lane_valid && wb.mu_valid) grant = WB_MU;
    push          = nRST && !full && (wb.lane_valid || wb.mu_valid);
    push_entry    = (grant == WB_LANE) ? {wb.lane_vd, wb.lane_data, wb.lane_mask}
                                       : {wb.mu_vd, wb.mu_data, wb.mu_mask};
    wb.lane_ready = nRST && !full && (grant == WB_LANE);
    wb.mu_ready   = nRST && !full && (grant == WB_MU);
    last_grant_d  = push ? grant : last_grant_q;
  end

  // Retirement handshake toward the VRF; head fields come straight from storage.
  always_comb begin
    pop            = !empty && wb.wr_ready;
    accomplished_d = pop;
    wb.wr_valid    = !empty;
    wb.wr_vd       = head_entry.vd;
    wb.wr_data     = head_entry.data;
    wb.wr_mask     = head_entry.mask;
    wb.count       = count;
  end

  // Arbiter pointer and retirement pulse registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_grant_q   <= WB_MU;
      accomplished_q <= 1'b0;
    end else begin
      last_grant_q   <= last_grant_d;
      accomplished_q <= accomplished_d;
    end
  end

  assign wb.accomplished = accomplished_q;

  // Pending lookup over live entries, head included even as it retires.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_vd[i] == wb.query_vd)) pending = 1'b1;
    end
    wb.query_pending = pending;
  end

endmodule

// File: tb/tb_vector_wb_buffer.sv
// Directed and randomized bench for vector_wb_buffer with a queue-based model.
module tb_vector_wb_buffer;
  import vector_wb_buffer_pkg::*;

  localparam int W = VEC_W;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  vector_wb_buffer_if wb();
  vector_wb_buffer dut (.CLK(CLK), .nRST(nRST), .wb(wb));

  int        tests = 0;
  int        fails = 0;
  wb_entry_t mq[$];
  bit        rr_mu;
  bit        exp_acc;
  int        retired;
  int        pushed;
  int        acc_seen;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One clock: check outputs against the model, then advance the model.
  task automatic cycle();
    bit lv, mv, full, g_lane, enq, deq, qp;
    wb_entry_t e;
    #1;
    lv     = wb.lane_valid;
    mv     = wb.mu_valid;
    full   = (mq.size() == WB_DEPTH);
    g_lane = lv && (!mv || rr_mu);
    enq    = !full && (lv || mv);
    qp     = 1'b0;
    foreach (mq[i]) if (mq[i].vd == wb.query_vd) qp = 1'b1;
    if (wb.accomplished === 1'b1) acc_seen++;
    chk("count", W'(wb.count), W'(mq.size()));
    chk("wr_valid", W'(wb.wr_valid), W'(mq.size() != 0));
    chk("accomplished", W'(wb.accomplished), W'(exp_acc));
    chk("query_pending", W'(wb.query_pending), W'(qp));
    if (lv) chk("lane_ready", W'(wb.lane_ready), W'(!full && g_lane));
    if (mv) chk("mu_ready", W'(wb.mu_ready), W'(!full && !g_lane));
    if (lv && !mv) chk("mu_ready_idle", W'(wb.mu_ready), W'(0));
    if (mv && !lv) chk("lane_ready_idle", W'(wb.lane_ready), W'(0));
    if (mq.size() != 0) begin
      chk("wr_vd", W'(wb.wr_vd), W'(mq[0].vd));
      chk("wr_data", wb.wr_data, mq[0].data);
      chk("wr_mask", W'(wb.wr_mask), W'(mq[0].mask));
    end
    deq = (mq.size() != 0) && wb.wr_ready;
    if (g_lane) e = '{vd: wb.lane_vd, data: wb.lane_data, mask: wb.lane_mask};
    else        e = '{vd: wb.mu_vd, data: wb.mu_data, mask: wb.mu_mask};
    @(posedge CLK);
    if (deq) begin
      void'(mq.pop_front());
      retired++;
    end
    if (enq) begin
      mq.push_back(e);
      rr_mu = !g_lane;
      pushed++;
    end
    exp_acc = deq;
    @(negedge CLK);
  endtask

  task automatic rand_producers(input int vd_max);
    wb.lane_vd   = VREG_IDX_W'($urandom_range(0, vd_max));
    wb.lane_data = rand_vec();
    wb.lane_mask = NUM_ELEMENTS'($urandom);
    wb.mu_vd     = VREG_IDX_W'($urandom_range(0, vd_max));
    wb.mu_data   = rand_vec();
    wb.mu_mask   = NUM_ELEMENTS'($urandom);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    int n;
    nRST = 1'b0;
    wb.lane_valid = 1'b1; wb.mu_valid = 1'b1; wb.wr_ready = 1'b0;
    wb.query_vd = '0;
    rand_producers(63);
    rr_mu = 1'b1; exp_acc = 1'b0; retired = 0; pushed = 0; acc_seen = 0;
    #12;
    chk("rst_wr_valid", W'(wb.wr_valid), W'(0));
    chk("rst_count", W'(wb.count), W'(0));
    chk("rst_acc", W'(wb.accomplished), W'(0));
    chk("rst_lane_ready", W'(wb.lane_ready), W'(0));
    chk("rst_mu_ready", W'(wb.mu_ready), W'(0));
    @(negedge CLK);
    nRST = 1'b1;
    wb.lane_valid = 1'b0; wb.mu_valid = 1'b0;
    cycle();

    // Lane-only single transfer with an FP16 1.0 pattern.
    wb.lane_vd = 6'd5; wb.lane_data = {NUM_ELEMENTS{16'h3C00}}; wb.lane_mask = '1;
    wb.lane_valid = 1'b1; wb.wr_ready = 1'b1;
    cycle();
    wb.lane_valid = 1'b0;
    #1;
    chk("t1_wr_valid", W'(wb.wr_valid), W'(1));
    chk("t1_wr_vd", W'(wb.wr_vd), W'(5));
    cycle();
    #1;
    chk("t1_acc", W'(wb.accomplished), W'(1));
    chk("t1_count", W'(wb.count), W'(0));
    cycle();
    // Mask-unit single transfer with an all-zero mask; leaves lane favored.
    wb.mu_vd = 6'd7; wb.mu_data = rand_vec(); wb.mu_mask = '0; wb.mu_valid = 1'b1;
    cycle();
    wb.mu_valid = 1'b0;
    cycle();
    cycle();

    // Contention with the VRF stalled: lane, mu, lane, mu then full.
    wb.wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_producers(63);
      wb.lane_valid = 1'b1; wb.mu_valid = 1'b1;
      #1;
      chk("rr_lane_ready", W'(wb.lane_ready), W'(i % 2 == 0));
      cycle();
    end
    cycle();
    #1;
    chk("full_count", W'(wb.count), W'(4));
    chk("full_lane_ready", W'(wb.lane_ready), W'(0));
    chk("full_mu_ready", W'(wb.mu_ready), W'(0));

    // Full with a simultaneous drain: no bypass, accept one cycle later.
    wb.mu_valid = 1'b0; wb.lane_valid = 1'b1; wb.wr_ready = 1'b1;
    rand_producers(63);
    cycle();
    #1;
    chk("drain_count", W'(wb.count), W'(3));
    chk("drain_lane_ready", W'(wb.lane_ready), W'(1));
    cycle();
    wb.lane_valid = 1'b0;
    n = 0;
    while (mq.size() != 0 && n < 20) begin cycle(); n++; end
    chk("drain_timeout", W'(mq.size()), W'(0));
    cycle();

    // Pending query across the life of one entry.
    wb.lane_vd = 6'd12; wb.lane_valid = 1'b1; wb.wr_ready = 1'b0;
    cycle();
    wb.lane_valid = 1'b0; wb.query_vd = 6'd12;
    #1;
    chk("q12_pending", W'(wb.query_pending), W'(1));
    wb.query_vd = 6'd13;
    #1;
    chk("q13_pending", W'(wb.query_pending), W'(0));
    wb.query_vd = 6'd12; wb.wr_ready = 1'b1;
    cycle();
    #1;
    chk("q12_retired", W'(wb.query_pending), W'(0));
    cycle();

    // Random backpressure: 8 entries retire in order with 8 pulses.
    acc0 = acc_seen; pushed = 0; retired = 0; n = 0;
    while ((retired < 8 || mq.size() != 0) && n < 400) begin
      rand_producers(7);
      wb.lane_valid = (pushed < 8) && ($urandom_range(0, 1) == 1);
      wb.mu_valid   = (pushed < 8) && ($urandom_range(0, 1) == 1);
      wb.wr_ready   = ($urandom_range(0, 1) == 1);
      wb.query_vd   = VREG_IDX_W'($urandom_range(0, 7));
      cycle();
      n++;
    end
    wb.lane_valid = 1'b0; wb.mu_valid = 1'b0;
    cycle();
    chk("bp_retired", W'(retired), W'(8));
    chk("bp_acc_pulses", W'(acc_seen - acc0), W'(8));

    // Asynchronous reset with three entries queued and a pulse in flight.
    wb.wr_ready = 1'b0; wb.lane_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin rand_producers(63); cycle(); end
    wb.lane_valid = 1'b0; wb.wr_ready = 1'b1;
    cycle();
    #1;
    chk("pre_rst_acc", W'(wb.accomplished), W'(1));
    chk("pre_rst_count", W'(wb.count), W'(3));
    wb.lane_valid = 1'b1; wb.mu_valid = 1'b1;
    #1;
    nRST = 1'b0;
    #1;
    chk("mid_rst_wr_valid", W'(wb.wr_valid), W'(0));
    chk("mid_rst_count", W'(wb.count), W'(0));
    chk("mid_rst_acc", W'(wb.accomplished), W'(0));
    chk("mid_rst_lane_ready", W'(wb.lane_ready), W'(0));
    chk("mid_rst_mu_ready", W'(wb.mu_ready), W'(0));
    wb.lane_valid = 1'b0; wb.mu_valid = 1'b0;
    mq.delete(); rr_mu = 1'b1; exp_acc = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
